// File: rtl/sev_seg_scan_n.sv
// Multiplexed seven-segment scanner: one digit per PRESCALE-cycle slot, inputs shadowed once per frame.
// Optional leading-zero suppression when SEV_SEG_LZ_BLANK_EN is defined; outputs are registered (latency 1).
module sev_seg_scan_n #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(PRESCALE);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] sh_dig;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic                    slot_end;
  logic                    frame_end;

  assign slot_end  = (cnt == CW'(PRESCALE - 1));
  assign frame_end = slot_end && (idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      sh_dig     <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= slot_end ? '0 : cnt + 1'b1;
      frame_tick <= frame_end;
      if (slot_end)
        idx <= frame_end ? '0 : idx + 1'b1;
      // Shadow only at the frame boundary so a frame never mixes old and new values.
      if (frame_end) begin
        sh_dig   <= digits;
        sh_dp    <= dp;
        sh_blank <= blank;
      end
    end
  end

  logic [NUM_DIGITS-1:0] lz_sup;

  always_comb begin
    lz_sup = '0;
`ifdef SEV_SEG_LZ_BLANK_EN
    begin
      logic zero_hi;
      zero_hi = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        zero_hi   = zero_hi && (sh_dig[4*i +: 4] == 4'h0);
        lz_sup[i] = zero_hi && !sh_dp[i];
      end
    end
`endif
  end

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    case (v)
      4'h0: hex_decode = 7'b0111111;
      4'h1: hex_decode = 7'b0000110;
      4'h2: hex_decode = 7'b1011011;
      4'h3: hex_decode = 7'b1001111;
      4'h4: hex_decode = 7'b1100110;
      4'h5: hex_decode = 7'b1101101;
      4'h6: hex_decode = 7'b1111101;
      4'h7: hex_decode = 7'b0000111;
      4'h8: hex_decode = 7'b1111111;
      4'h9: hex_decode = 7'b1101111;
      4'hA: hex_decode = 7'b1110111;
      4'hB: hex_decode = 7'b1111100;
      4'hC: hex_decode = 7'b0111001;
      4'hD: hex_decode = 7'b1011110;
      4'hE: hex_decode = 7'b1111001;
      default: hex_decode = 7'b1110001;
    endcase
  endfunction

  logic [3:0]            cur_dig;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [6:0]            seg_raw;
  logic                  dp_raw;
  logic [NUM_DIGITS-1:0] an_raw;

  always_comb begin
    cur_dig   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_dig   = sh_dig[4*i +: 4];
        cur_dp    = sh_dp[i];
        cur_blank = sh_blank[i] | lz_sup[i];
      end
    end
    an_raw = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      an_raw[i] = (idx == IW'(i)) && !cur_blank;
    seg_raw = cur_blank ? 7'b0 : hex_decode(cur_dig);
    dp_raw  = cur_dp && !cur_blank;
  end

  // Polarity is applied only here; everything upstream is active-high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg    <= {7{ACTIVE_LOW}};
      seg_dp <= ACTIVE_LOW;
      an     <= {NUM_DIGITS{ACTIVE_LOW}};
    end else begin
      seg    <= seg_raw ^ {7{ACTIVE_LOW}};
      seg_dp <= dp_raw ^ ACTIVE_LOW;
      an     <= an_raw ^ {NUM_DIGITS{ACTIVE_LOW}};
    end
  end

endmodule
